bp_fe_bp_pred_tracker: RTL and testbench

//  Sits directly downstream of the FE branch predictor. Captures each prediction (PC + taken bit)

---
 rtl/bp_fe_bp_pkg.sv | 18 +
 rtl/bp_fe_bp_pred_fifo.sv | 63 ++++++
 rtl/bp_fe_bp_pred_tracker.sv | 122 ++++++++++++
 tb/tb_bp_fe_bp_pred_tracker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_bp_pkg.sv
// Shared types for the FE branch-prediction tracker: queue entry layout and pointer width.
// Entry PC width comes from the BP_FE_BP_PC_WIDTH_P macro (default 39).
`ifndef BP_FE_BP_PC_WIDTH_P
`define BP_FE_BP_PC_WIDTH_P 39
`endif

package bp_fe_bp_pkg;

    localparam int pc_width_lp  = `BP_FE_BP_PC_WIDTH_P;
    localparam int depth_lp     = 8;
    localparam int ptr_width_lp = $clog2(depth_lp) + 1;

    typedef struct packed {
        logic [pc_width_lp-1:0] pc;
        logic                   pred;
    } bp_pred_entry_s;

endpackage

// File: rtl/bp_fe_bp_pred_fifo.sv
// In-order queue of outstanding predictions with wrap-bit pointers and flush.
// Callers present already-qualified enqueue/dequeue strobes.
module bp_fe_bp_pred_fifo
    import bp_fe_bp_pkg::*;
#(
    parameter int depth_p = depth_lp
)
(
    input  logic           clk_i,
    input  logic           reset_n_i,
    input  logic           flush_i,
    input  logic           enq_v_i,
    input  bp_pred_entry_s enq_data_i,
    input  logic           deq_v_i,
    output bp_pred_entry_s deq_data_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int ptr_w_lp = $clog2(depth_p) + 1;
    localparam int idx_w_lp = ptr_w_lp - 1;
    localparam logic [ptr_w_lp-1:0] ptr_one_lp = {{idx_w_lp{1'b0}}, 1'b1};
    localparam int entry_w_lp = $bits(bp_pred_entry_s);

    bp_pred_entry_s      mem_r [depth_p];
    logic [ptr_w_lp-1:0] rd_ptr_r;
    logic [ptr_w_lp-1:0] wr_ptr_r;

    assign empty_o    = (rd_ptr_r == wr_ptr_r);
    assign full_o     = (rd_ptr_r[idx_w_lp-1:0] == wr_ptr_r[idx_w_lp-1:0]) &
                        (rd_ptr_r[idx_w_lp] != wr_ptr_r[idx_w_lp]);
    assign deq_data_o = mem_r[rd_ptr_r[idx_w_lp-1:0]];

    // Pointer update; flush rewinds both pointers to the start of the ring.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= {ptr_w_lp{1'b0}};
            wr_ptr_r <= {ptr_w_lp{1'b0}};
        end else if (flush_i) begin
            rd_ptr_r <= {ptr_w_lp{1'b0}};
            wr_ptr_r <= {ptr_w_lp{1'b0}};
        end else begin
            if (enq_v_i) begin
                wr_ptr_r <= wr_ptr_r + ptr_one_lp;
            end
            if (deq_v_i) begin
                rd_ptr_r <= rd_ptr_r + ptr_one_lp;
            end
        end
    end

    // Entry storage, cleared on reset so a read of an unused slot is deterministic.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < depth_p; i++) begin
                mem_r[i] <= bp_pred_entry_s'({entry_w_lp{1'b0}});
            end
        end else if (enq_v_i) begin
            mem_r[wr_ptr_r[idx_w_lp-1:0]] <= enq_data_i;
        end
    end

endmodule

// File: rtl/bp_fe_bp_pred_tracker.sv
// Tracks FE branch predictions until resolution and emits training updates / mispredict pulses.
// Optional BP_PRED_TRACKER_STATS_EN adds saturating resolved/mispredicted counters.
module bp_fe_bp_pred_tracker
    import bp_fe_bp_pkg::*;
#(
    parameter int depth_p    = 8,
    parameter int pc_width_p = `BP_FE_BP_PC_WIDTH_P
`ifdef BP_PRED_TRACKER_STATS_EN
    ,
    parameter int cnt_width_p = 32
`endif
)
(
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  r_v_i,
    input  logic [pc_width_p-1:0] r_pc_i,
    input  logic                  predict_i,
    output logic                  r_ready_o,
    input  logic                  w_v_i,
    input  logic                  w_taken_i,
    output logic                  w_ready_o,
    input  logic                  flush_i,
    output logic                  upd_v_o,
    output logic [pc_width_p-1:0] upd_pc_o,
    output logic                  upd_taken_o,
    output logic                  mispredict_o
`ifdef BP_PRED_TRACKER_STATS_EN
    ,
    output logic [cnt_width_p-1:0] stat_total_o,
    output logic [cnt_width_p-1:0] stat_miss_o
`endif
);

    logic           full_s;
    logic           empty_s;
    logic           enq_fire_s;
    logic           deq_fire_s;
    logic           miss_s;
    bp_pred_entry_s enq_data_s;
    bp_pred_entry_s deq_data_s;

    logic                  upd_v_r;
    logic [pc_width_p-1:0] upd_pc_r;
    logic                  upd_taken_r;
    logic                  mispredict_r;

    assign r_ready_o  = ~full_s;
    assign w_ready_o  = ~empty_s;
    assign enq_fire_s = r_v_i & ~full_s & ~flush_i;
    assign deq_fire_s = w_v_i & ~empty_s & ~flush_i;
    assign enq_data_s = '{pc: r_pc_i, pred: predict_i};
    assign miss_s     = deq_data_s.pred ^ w_taken_i;

    bp_fe_bp_pred_fifo #(
        .depth_p (depth_p)
    ) fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .flush_i    (flush_i),
        .enq_v_i    (enq_fire_s),
        .enq_data_i (enq_data_s),
        .deq_v_i    (deq_fire_s),
        .deq_data_o (deq_data_s),
        .full_o     (full_s),
        .empty_o    (empty_s)
    );

    // Update strobes: pulse exactly one cycle after an accepted resolution.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            upd_v_r      <= 1'b0;
            mispredict_r <= 1'b0;
        end else begin
            upd_v_r      <= deq_fire_s;
            mispredict_r <= deq_fire_s & miss_s;
        end
    end

    // Update payload holds its last value between updates.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            upd_pc_r    <= {pc_width_p{1'b0}};
            upd_taken_r <= 1'b0;
        end else if (deq_fire_s) begin
            upd_pc_r    <= deq_data_s.pc;
            upd_taken_r <= w_taken_i;
        end
    end

    assign upd_v_o      = upd_v_r;
    assign upd_pc_o     = upd_pc_r;
    assign upd_taken_o  = upd_taken_r;
    assign mispredict_o = mispredict_r;

`ifdef BP_PRED_TRACKER_STATS_EN
    localparam logic [cnt_width_p-1:0] cnt_one_lp = {{(cnt_width_p-1){1'b0}}, 1'b1};
    localparam logic [cnt_width_p-1:0] cnt_max_lp = {cnt_width_p{1'b1}};

    logic [cnt_width_p-1:0] stat_total_r;
    logic [cnt_width_p-1:0] stat_miss_r;

    // Saturating statistics; counted alongside the update they describe, untouched by flush.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stat_total_r <= {cnt_width_p{1'b0}};
            stat_miss_r  <= {cnt_width_p{1'b0}};
        end else begin
            if (deq_fire_s && (stat_total_r != cnt_max_lp)) begin
                stat_total_r <= stat_total_r + cnt_one_lp;
            end
            if (deq_fire_s && miss_s && (stat_miss_r != cnt_max_lp)) begin
                stat_miss_r <= stat_miss_r + cnt_one_lp;
            end
        end
    end

    assign stat_total_o = stat_total_r;
    assign stat_miss_o  = stat_miss_r;
`endif

endmodule

// File: tb/tb_bp_fe_bp_pred_tracker.sv
// Directed self-checking bench for bp_fe_bp_pred_tracker (depth 8, 39-bit PC).
// With BP_PRED_TRACKER_STATS_EN the counters are built 4 bits wide to reach saturation.
module tb_bp_fe_bp_pred_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r_v;
    logic [38:0] r_pc;
    logic        predict;
    logic        r_ready;
    logic        w_v;
    logic        w_taken;
    logic        w_ready;
    logic        flush;
    logic        upd_v;
    logic [38:0] upd_pc;
    logic        upd_taken;
    logic        mispredict;
`ifdef BP_PRED_TRACKER_STATS_EN
    logic [3:0]  stat_total;
    logic [3:0]  stat_miss;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bp_fe_bp_pred_tracker #(
        .depth_p     (8),
        .pc_width_p  (39)
`ifdef BP_PRED_TRACKER_STATS_EN
        ,
        .cnt_width_p (4)
`endif
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .r_v_i        (r_v),
        .r_pc_i       (r_pc),
        .predict_i    (predict),
        .r_ready_o    (r_ready),
        .w_v_i        (w_v),
        .w_taken_i    (w_taken),
        .w_ready_o    (w_ready),
        .flush_i      (flush),
        .upd_v_o      (upd_v),
        .upd_pc_o     (upd_pc),
        .upd_taken_o  (upd_taken),
        .mispredict_o (mispredict)
`ifdef BP_PRED_TRACKER_STATS_EN
        ,
        .stat_total_o (stat_total),
        .stat_miss_o  (stat_miss)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [38:0] pc, input logic pred);
        r_v = 1'b1; r_pc = pc; predict = pred;
        tick();
        r_v = 1'b0;
    endtask

    task automatic resolve(input logic taken);
        w_v = 1'b1; w_taken = taken;
        tick();
        w_v = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; r_v = 1'b0; r_pc = 39'h0; predict = 1'b0;
        w_v = 1'b0; w_taken = 1'b0; flush = 1'b0;
        #3;
        n_checks++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL reset_r_ready: got %0h expected 1", r_ready); end
        n_checks++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL reset_w_ready: got %0h expected 0", w_ready); end
        n_checks++; if (upd_v !== 1'b0) begin n_fail++; $display("FAIL reset_upd_v: got %0h expected 0", upd_v); end
        n_checks++; if (upd_pc !== 39'h0) begin n_fail++; $display("FAIL reset_upd_pc: got %0h expected 0", upd_pc); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict: got %0h expected 0", mispredict); end
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        enq(39'h100, 1'b1);
        n_checks++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL basic_w_ready: got %0h expected 1", w_ready); end
        tick();
        resolve(1'b1);
        n_checks++; if (upd_v !== 1'b1) begin n_fail++; $display("FAIL basic_upd_v: got %0h expected 1", upd_v); end
        n_checks++; if (upd_pc !== 39'h100) begin n_fail++; $display("FAIL basic_upd_pc: got %0h expected 100", upd_pc); end
        n_checks++; if (upd_taken !== 1'b1) begin n_fail++; $display("FAIL basic_upd_taken: got %0h expected 1", upd_taken); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL basic_mispredict: got %0h expected 0", mispredict); end
        tick();
        n_checks++; if (upd_v !== 1'b0) begin n_fail++; $display("FAIL basic_upd_v_drop: got %0h expected 0", upd_v); end
        n_checks++; if (upd_pc !== 39'h100) begin n_fail++; $display("FAIL basic_upd_pc_hold: got %0h expected 100", upd_pc); end
    endtask

    task automatic test_mispredict();
        enq(39'h200, 1'b0);
        resolve(1'b1);
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL misp_pulse: got %0h expected 1", mispredict); end
        n_checks++; if (upd_taken !== 1'b1) begin n_fail++; $display("FAIL misp_upd_taken: got %0h expected 1", upd_taken); end
        n_checks++; if (upd_pc !== 39'h200) begin n_fail++; $display("FAIL misp_upd_pc: got %0h expected 200", upd_pc); end
        tick();
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL misp_one_cycle: got %0h expected 0", mispredict); end
        // capture and resolve in the same cycle on an empty queue: no bypass
        r_v = 1'b1; r_pc = 39'h300; predict = 1'b1; w_v = 1'b1; w_taken = 1'b1;
        tick();
        r_v = 1'b0;
        n_checks++; if (upd_v !== 1'b0) begin n_fail++; $display("FAIL nobypass_upd_v: got %0h expected 0", upd_v); end
        tick();
        w_v = 1'b0;
        n_checks++; if (upd_v !== 1'b1) begin n_fail++; $display("FAIL nobypass_late_upd_v: got %0h expected 1", upd_v); end
        n_checks++; if (upd_pc !== 39'h300) begin n_fail++; $display("FAIL nobypass_upd_pc: got %0h expected 300", upd_pc); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL nobypass_mispredict: got %0h expected 0", mispredict); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            enq(39'h1000 + 39'(i), i[0]);
        end
        n_checks++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL fill_r_ready: got %0h expected 0", r_ready); end
        enq(39'hDEAD, 1'b0);
        n_checks++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL fill_drop_r_ready: got %0h expected 0", r_ready); end
        w_v = 1'b1; w_taken = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (upd_pc !== 39'h1000 + 39'(i)) begin n_fail++; $display("FAIL drain_pc[%0d]: got %0h expected %0h", i, upd_pc, 39'h1000 + 39'(i)); end
            n_checks++; if (mispredict !== i[0]) begin n_fail++; $display("FAIL drain_misp[%0d]: got %0h expected %0h", i, mispredict, i[0]); end
        end
        n_checks++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL drain_w_ready: got %0h expected 0", w_ready); end
        tick();
        w_v = 1'b0;
        n_checks++; if (upd_v !== 1'b0) begin n_fail++; $display("FAIL empty_resolve_upd_v: got %0h expected 0", upd_v); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL empty_resolve_misp: got %0h expected 0", mispredict); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            enq(39'h2000 + 39'(i), 1'b0);
        end
        n_checks++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %0h expected 0", r_ready); end
        r_v = 1'b1; r_pc = 39'h3000; predict = 1'b1; w_v = 1'b1; w_taken = 1'b1;
        tick();
        r_v = 1'b0; w_v = 1'b0;
        n_checks++; if (upd_pc !== 39'h2000) begin n_fail++; $display("FAIL b2b_upd_pc: got %0h expected 2000", upd_pc); end
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL b2b_misp: got %0h expected 1", mispredict); end
        n_checks++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_r_ready: got %0h expected 1", r_ready); end
        w_v = 1'b1; w_taken = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            n_checks++; if (upd_pc !== 39'h2000 + 39'(i)) begin n_fail++; $display("FAIL b2b_drain_pc[%0d]: got %0h expected %0h", i, upd_pc, 39'h2000 + 39'(i)); end
        end
        w_v = 1'b0;
        n_checks++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_occupancy7: got %0h expected 0", w_ready); end
    endtask

    task automatic test_flush();
        enq(39'h4000, 1'b0); enq(39'h4001, 1'b0); enq(39'h4002, 1'b0);
        flush = 1'b1; w_v = 1'b1; w_taken = 1'b1; r_v = 1'b1; r_pc = 39'h4444;
        tick();
        flush = 1'b0; w_v = 1'b0; r_v = 1'b0;
        n_checks++; if (upd_v !== 1'b0) begin n_fail++; $display("FAIL flush_upd_v: got %0h expected 0", upd_v); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL flush_misp: got %0h expected 0", mispredict); end
        n_checks++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL flush_w_ready: got %0h expected 0", w_ready); end
        n_checks++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL flush_r_ready: got %0h expected 1", r_ready); end
        n_checks++; if (upd_pc !== 39'h2007) begin n_fail++; $display("FAIL flush_pc_hold: got %0h expected 2007", upd_pc); end
        // update registered before a flush still shows, then nothing follows
        enq(39'h4100, 1'b1); enq(39'h4101, 1'b1);
        resolve(1'b0);
        flush = 1'b1;
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL flush_inflight_misp: got %0h expected 1", mispredict); end
        tick();
        flush = 1'b0;
        n_checks++; if (upd_v !== 1'b0) begin n_fail++; $display("FAIL flush_after_upd_v: got %0h expected 0", upd_v); end
        n_checks++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL flush_after_w_ready: got %0h expected 0", w_ready); end
        enq(39'h5000, 1'b1);
        resolve(1'b0);
        n_checks++; if (upd_pc !== 39'h5000) begin n_fail++; $display("FAIL postflush_pc: got %0h expected 5000", upd_pc); end
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL postflush_misp: got %0h expected 1", mispredict); end
    endtask

`ifdef BP_PRED_TRACKER_STATS_EN
    task automatic test_stats();
        reset_n = 1'b0; #2; reset_n = 1'b1;
        tick();
        n_checks++; if (stat_total !== 4'd0) begin n_fail++; $display("FAIL stats_reset_total: got %0d expected 0", stat_total); end
        enq(39'h10, 1'b1); resolve(1'b1);
        n_checks++; if (stat_total !== 4'd1) begin n_fail++; $display("FAIL stats_total1: got %0d expected 1", stat_total); end
        n_checks++; if (stat_miss !== 4'd0) begin n_fail++; $display("FAIL stats_miss0: got %0d expected 0", stat_miss); end
        for (int i = 0; i < 17; i++) begin
            enq(39'h20 + 39'(i), 1'b1); resolve(1'b0);
            if (i == 2) begin
                n_checks++; if (stat_miss !== 4'd3) begin n_fail++; $display("FAIL stats_miss3: got %0d expected 3", stat_miss); end
                n_checks++; if (stat_total !== 4'd4) begin n_fail++; $display("FAIL stats_total4: got %0d expected 4", stat_total); end
            end
        end
        n_checks++; if (stat_miss !== 4'd15) begin n_fail++; $display("FAIL stats_miss_sat: got %0d expected 15", stat_miss); end
        n_checks++; if (stat_total !== 4'd15) begin n_fail++; $display("FAIL stats_total_sat: got %0d expected 15", stat_total); end
        flush = 1'b1; tick(); flush = 1'b0;
        n_checks++; if (stat_miss !== 4'd15) begin n_fail++; $display("FAIL stats_flush_keep: got %0d expected 15", stat_miss); end
    endtask
`endif

    task automatic test_reset_mid();
        enq(39'h6000, 1'b1); enq(39'h6001, 1'b0);
        resolve(1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (upd_v !== 1'b0) begin n_fail++; $display("FAIL rstmid_upd_v: got %0h expected 0", upd_v); end
        n_checks++; if (upd_pc !== 39'h0) begin n_fail++; $display("FAIL rstmid_upd_pc: got %0h expected 0", upd_pc); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL rstmid_misp: got %0h expected 0", mispredict); end
        n_checks++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_w_ready: got %0h expected 0", w_ready); end
        n_checks++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_r_ready: got %0h expected 1", r_ready); end
`ifdef BP_PRED_TRACKER_STATS_EN
        n_checks++; if (stat_total !== 4'd0) begin n_fail++; $display("FAIL rstmid_stat_total: got %0d expected 0", stat_total); end
        n_checks++; if (stat_miss !== 4'd0) begin n_fail++; $display("FAIL rstmid_stat_miss: got %0d expected 0", stat_miss); end
`endif
        #2;
        reset_n = 1'b1;
        w_v = 1'b1; w_taken = 1'b0;
        tick();
        w_v = 1'b0;
        n_checks++; if (upd_v !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped: got %0h expected 0", upd_v); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mispredict();
        test_fill_drain();
        test_back_to_back();
        test_flush();
`ifdef BP_PRED_TRACKER_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
